// File: rtl/chip8_fetch.sv
// CHIP-8 fetch: reads two bytes at pc/pc+1 and presents a big-endian opcode; optional FETCH_ALIGN_CHECK_EN traps odd redirects.
// Latency: op_valid rises 3 cycles after entering F_HI; one opcode per 4 cycles with op_ready held high.
// Backpressure: holds opcode/op_pc/op_valid and issues no reads while op_ready is low; redirect overrides everything but rst.
module chip8_fetch #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = 'h200
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       opcode,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_fault
);

    typedef enum logic [2:0] {
        F_HI  = 3'd0,
        F_LO  = 3'd1,
        W_LO  = 3'd2,
        VALID = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
        ,FAULT = 3'd4
`endif
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [7:0]        hi, hi_nx;
    logic [15:0]       opcode_nx;
    logic [ADDR_W-1:0] op_pc_nx;
    logic              op_valid_nx;
    logic              redirect_take;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_nx;
    assign fetch_fault   = fault_q;
    assign redirect_take = redirect && (state != FAULT);
`else
    assign fetch_fault   = 1'b0;
    assign redirect_take = redirect;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= F_HI;
            pc       <= RESET_PC;
            hi       <= 8'h00;
            opcode   <= 16'h0000;
            op_pc    <= '0;
            op_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            hi       <= hi_nx;
            opcode   <= opcode_nx;
            op_pc    <= op_pc_nx;
            op_valid <= op_valid_nx;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q  <= fault_nx;
`endif
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        hi_nx       = hi;
        opcode_nx   = opcode;
        op_pc_nx    = op_pc;
        op_valid_nx = op_valid;
        mem_rd      = 1'b0;
        mem_addr    = pc;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_nx    = fault_q;
`endif

        case (state)
            F_HI: begin
                mem_rd   = 1'b1;
                state_nx = F_LO;
            end
            F_LO: begin
                mem_rd   = 1'b1;
                mem_addr = pc + ADDR_W'(1);
                hi_nx    = mem_rdata;
                state_nx = W_LO;
            end
            W_LO: begin
                opcode_nx   = {hi, mem_rdata};
                op_pc_nx    = pc;
                op_valid_nx = 1'b1;
                state_nx    = VALID;
            end
            VALID: begin
                if (op_valid && op_ready) begin
                    pc_nx       = pc + ADDR_W'(2);
                    op_valid_nx = 1'b0;
                    state_nx    = F_HI;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: begin
                op_valid_nx = 1'b0;
            end
`endif
            default: begin
                state_nx    = F_HI;
                op_valid_nx = 1'b0;
            end
        endcase

        // Redirect wins over any handshake; read data still returning from the old stream is dropped.
        if (redirect_take) begin
            pc_nx       = redirect_pc;
            hi_nx       = 8'h00;
            op_valid_nx = 1'b0;
            state_nx    = F_HI;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[0]) begin
                state_nx = FAULT;
                fault_nx = 1'b1;
            end
`endif
        end

        if (rst) begin
            mem_rd = 1'b0;
        end
    end

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed test of chip8_fetch against a 1-cycle-latency byte memory model.
module tb_chip8_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] opcode;
    logic [11:0] op_pc;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        fetch_fault;

    logic [7:0]  mem [0:4095];
    int          checks   = 0;
    int          failures = 0;

    chip8_fetch #(.ADDR_W(12), .RESET_PC(12'h200)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .opcode      (opcode),
        .op_pc       (op_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Leaves the bench 1 time unit after the negedge on which rst dropped (DUT in F_HI).
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (op_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        op_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 12'h300;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        checks++; if (opcode !== 16'h0000) begin failures++; $display("FAIL reset_opcode got=%h exp=0000", opcode); end
        checks++; if (op_pc !== 12'h000) begin failures++; $display("FAIL reset_op_pc got=%h exp=000", op_pc); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
        redirect = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h200) begin failures++; $display("FAIL reset_first_addr got=%b/%h exp=1/200", mem_rd, mem_addr); end
    endtask

    task automatic test_basic();
        int n;
        op_ready = 1'b1;
        apply_reset();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h200) begin failures++; $display("FAIL basic_hi_addr got=%b/%h exp=1/200", mem_rd, mem_addr); end
        @(negedge clk); #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h201) begin failures++; $display("FAIL basic_lo_addr got=%b/%h exp=1/201", mem_rd, mem_addr); end
        @(negedge clk); #1;
        checks++; if (mem_rd !== 1'b0 || op_valid !== 1'b0) begin failures++; $display("FAIL basic_wlo got=%b/%b exp=0/0", mem_rd, op_valid); end
        @(negedge clk); #1;
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", op_valid); end
        checks++; if (opcode !== 16'h1234 || op_pc !== 12'h200) begin failures++; $display("FAIL basic_opcode got=%h@%h exp=1234@200", opcode, op_pc); end
        @(negedge clk); #1;
        checks++; if (op_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 12'h202) begin failures++; $display("FAIL basic_next got=%b/%b/%h exp=0/1/202", op_valid, mem_rd, mem_addr); end
        wait_valid(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL basic_throughput got=%0d exp=3", n); end
        checks++; if (opcode !== 16'h5678 || op_pc !== 12'h202) begin failures++; $display("FAIL basic_second got=%h@%h exp=5678@202", opcode, op_pc); end
    endtask

    task automatic test_stall();
        int n;
        int bad;
        op_ready = 1'b0;
        apply_reset();
        wait_valid(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL stall_wait got=%0d exp=3", n); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (op_valid !== 1'b1 || mem_rd !== 1'b0 || opcode !== 16'h1234 || op_pc !== 12'h200) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0 || mem_addr !== 12'h202) begin failures++; $display("FAIL stall_release got=%b/%h exp=0/202", op_valid, mem_addr); end
        wait_valid(n);
        checks++; if (op_pc !== 12'h202 || opcode !== 16'h5678) begin failures++; $display("FAIL stall_single got=%h@%h exp=5678@202", opcode, op_pc); end
    endtask

    task automatic test_redirect();
        int n;
        op_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 12'h300;
        #1;
        checks++; if (mem_addr !== 12'h201) begin failures++; $display("FAIL redir_old_state got=%h exp=201", mem_addr); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h300 || op_valid !== 1'b0) begin failures++; $display("FAIL redir_addr got=%b/%h/%b exp=1/300/0", mem_rd, mem_addr, op_valid); end
        wait_valid(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL redir_latency got=%0d exp=3", n); end
        checks++; if (opcode !== 16'hA0B1 || op_pc !== 12'h300) begin failures++; $display("FAIL redir_opcode got=%h@%h exp=a0b1@300", opcode, op_pc); end
    endtask

    task automatic test_back_to_back();
        int n;
        op_ready = 1'b1;
        apply_reset();
        wait_valid(n);
        @(negedge clk); #1;
        wait_valid(n);
        checks++; if (op_pc !== 12'h202) begin failures++; $display("FAIL b2b_pre got=%h exp=202", op_pc); end
        redirect = 1'b1;
        redirect_pc = 12'h400;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0 || mem_addr !== 12'h400) begin failures++; $display("FAIL b2b_addr got=%b/%h exp=0/400", op_valid, mem_addr); end
        wait_valid(n);
        checks++; if (opcode !== 16'hC2D3 || op_pc !== 12'h400) begin failures++; $display("FAIL b2b_opcode got=%h@%h exp=c2d3@400", opcode, op_pc); end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_fault();
        op_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 12'h201;
        @(negedge clk);
        redirect_pc = 12'h300;
        #1;
        checks++; if (fetch_fault !== 1'b1 || op_valid !== 1'b0 || mem_rd !== 1'b0) begin failures++; $display("FAIL fault_set got=%b/%b/%b exp=1/0/0", fetch_fault, op_valid, mem_rd); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (fetch_fault !== 1'b1 || mem_rd !== 1'b0 || op_valid !== 1'b0) begin failures++; $display("FAIL fault_sticky got=%b/%b/%b exp=1/0/0", fetch_fault, mem_rd, op_valid); end
        apply_reset();
        checks++; if (fetch_fault !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 12'h200) begin failures++; $display("FAIL fault_clear got=%b/%b/%h exp=0/1/200", fetch_fault, mem_rd, mem_addr); end
    endtask
`else
    task automatic test_wrap();
        int n;
        op_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 12'hFFF;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (mem_addr !== 12'hFFF || fetch_fault !== 1'b0) begin failures++; $display("FAIL wrap_hi got=%h/%b exp=fff/0", mem_addr, fetch_fault); end
        @(negedge clk); #1;
        checks++; if (mem_addr !== 12'h000) begin failures++; $display("FAIL wrap_lo got=%h exp=000", mem_addr); end
        wait_valid(n);
        checks++; if (opcode !== 16'hABCD || op_pc !== 12'hFFF) begin failures++; $display("FAIL wrap_opcode got=%h@%h exp=abcd@fff", opcode, op_pc); end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        #1;
        checks++; if (mem_addr !== 12'h001 || fetch_fault !== 1'b0) begin failures++; $display("FAIL wrap_next got=%h/%b exp=001/0", mem_addr, fetch_fault); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        op_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 12'h000;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
        mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
        mem[12'h300] = 8'hA0; mem[12'h301] = 8'hB1;
        mem[12'h400] = 8'hC2; mem[12'h401] = 8'hD3;
        mem[12'hFFF] = 8'hAB; mem[12'h000] = 8'hCD;
        mem[12'h001] = 8'hEE;

        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_back_to_back();
`ifdef FETCH_ALIGN_CHECK_EN
        test_fault();
`else
        test_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
